// File: rtl/input_vc_controller_if.sv
// Handshake/bus bundle of one input virtual channel.
//   slave  : seen by input_vc_controller (flit in, VA and switch handshakes, status out)
//   master : seen by the upstream link / allocators driving the VC
// Signal names keep the controller's own _i/_o orientation.
interface input_vc_controller_if #(
    parameter int unsigned BUFFER_SIZE = 8,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned VC_SIZE     = 1
);
    localparam int unsigned FW = DATA_W + 2;
    localparam int unsigned CW = $clog2(BUFFER_SIZE) + 1;

    logic               valid_i;
    logic [FW-1:0]      flit_i;
    logic               vc_request_o;
    logic [2:0]         out_port_o;
    logic               vc_valid_i;
    logic [VC_SIZE-1:0] vc_new_i;
    logic               switch_request_o;
    logic               switch_grant_i;
    logic [FW-1:0]      flit_o;
    logic [VC_SIZE-1:0] vc_o;
    logic               idle_o;
    logic [CW-1:0]      count_o;
    logic               error_o;

    modport slave (
        input  valid_i, flit_i, vc_valid_i, vc_new_i, switch_grant_i,
        output vc_request_o, out_port_o, switch_request_o, flit_o, vc_o,
               idle_o, count_o, error_o
    );

    modport master (
        output valid_i, flit_i, vc_valid_i, vc_new_i, switch_grant_i,
        input  vc_request_o, out_port_o, switch_request_o, flit_o, vc_o,
               idle_o, count_o, error_o
    );
endinterface

// File: rtl/input_vc_controller.sv
// Input virtual-channel controller: circular flit FIFO, XY route computation
// on head flits, VC allocation request and per-flit switch requests.
//   clk    : clock, rising edge
//   rst    : synchronous active-low reset
//   vc_if  : slave side of input_vc_controller_if
//            valid_i/flit_i in; vc_request_o/out_port_o with vc_valid_i/vc_new_i;
//            switch_request_o with switch_grant_i; flit_o (FIFO head, combinational),
//            vc_o, idle_o, count_o, error_o (sticky protocol error)
module input_vc_controller #(
    parameter int unsigned BUFFER_SIZE = 8,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned COORD_W     = 2,
    parameter int unsigned VC_SIZE     = 1,
    parameter int unsigned ROUTER_X    = 0,
    parameter int unsigned ROUTER_Y    = 0
) (
    input logic                  clk,
    input logic                  rst,
    input_vc_controller_if.slave vc_if
);
    localparam int unsigned FW = DATA_W + 2;
    localparam int unsigned AW = $clog2(BUFFER_SIZE);
    localparam int unsigned PW = AW + 1;

    localparam logic [1:0] T_HEAD     = 2'b00;
    localparam logic [1:0] T_TAIL     = 2'b10;
    localparam logic [1:0] T_HEADTAIL = 2'b11;

    localparam logic [2:0] P_LOCAL = 3'd0;
    localparam logic [2:0] P_NORTH = 3'd1;
    localparam logic [2:0] P_SOUTH = 3'd2;
    localparam logic [2:0] P_WEST  = 3'd3;
    localparam logic [2:0] P_EAST  = 3'd4;

    localparam logic [COORD_W-1:0] MY_X = COORD_W'(ROUTER_X);
    localparam logic [COORD_W-1:0] MY_Y = COORD_W'(ROUTER_Y);

    typedef enum logic [1:0] {S_IDLE, S_VA, S_ACTIVE} state_e;

    logic [FW-1:0]      mem_q [BUFFER_SIZE];
    logic [PW-1:0]      wr_q, wr_d, rd_q, rd_d;
    state_e             state_q, state_d;
    logic [2:0]         port_q, port_d;
    logic [VC_SIZE-1:0] vc_q, vc_d;
    logic               err_q, err_d;

    logic               empty, full, push, pop;
    logic [FW-1:0]      head;
    logic [1:0]         head_type;
    logic [COORD_W-1:0] dest_x, dest_y;
    logic [2:0]         route;

    // FIFO status; the pointer MSB is the wrap bit
    assign head      = mem_q[rd_q[AW-1:0]];
    assign head_type = head[1:0];
    assign dest_x    = head[2 +: COORD_W];
    assign dest_y    = head[2+COORD_W +: COORD_W];
    assign empty     = (wr_q == rd_q);
    assign full      = (wr_q[AW-1:0] == rd_q[AW-1:0]) && (wr_q[AW] != rd_q[AW]);

    // XY dimension-order routing: resolve X first, then Y
    always_comb begin
        route = P_LOCAL;
        if (dest_x > MY_X)      route = P_EAST;
        else if (dest_x < MY_X) route = P_WEST;
        else if (dest_y > MY_Y) route = P_SOUTH;
        else if (dest_y < MY_Y) route = P_NORTH;
    end

    // Next-state, pop/push and sticky error logic
    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        vc_d    = vc_q;
        err_d   = err_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    if (head_type == T_HEAD || head_type == T_HEADTAIL) begin
                        port_d  = route;
                        state_d = S_VA;
                    end else begin
                        // orphan BODY/TAIL without a head: drop it
                        pop   = 1'b1;
                        err_d = 1'b1;
                    end
                end
            end
            S_VA: begin
                if (vc_if.vc_valid_i) begin
                    vc_d    = vc_if.vc_new_i;
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (vc_if.switch_grant_i && !empty) begin
                    pop = 1'b1;
                    if (head_type == T_TAIL || head_type == T_HEADTAIL) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (vc_if.vc_valid_i && state_q != S_VA) err_d = 1'b1;
        if (vc_if.switch_grant_i && (state_q != S_ACTIVE || empty)) err_d = 1'b1;
        // a full FIFO accepts a write only when a flit leaves the same cycle
        push = vc_if.valid_i && (!full || pop);
        if (vc_if.valid_i && full && !pop) err_d = 1'b1;
        wr_d = wr_q + PW'(push);
        rd_d = rd_q + PW'(pop);
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            state_q <= S_IDLE;
            port_q  <= '0;
            vc_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            state_q <= state_d;
            port_q  <= port_d;
            vc_q    <= vc_d;
            err_q   <= err_d;
        end
    end

    // Flit storage (contents are don't-care after reset)
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q[AW-1:0]] <= vc_if.flit_i;
    end

    assign vc_if.vc_request_o     = (state_q == S_VA);
    assign vc_if.out_port_o       = port_q;
    assign vc_if.switch_request_o = (state_q == S_ACTIVE) && !empty;
    assign vc_if.flit_o           = head;
    assign vc_if.vc_o             = vc_q;
    assign vc_if.idle_o           = (state_q == S_IDLE) && empty;
    assign vc_if.count_o          = wr_q - rd_q;
    assign vc_if.error_o          = err_q;
endmodule

// File: tb/tb_input_vc_controller.sv
// Directed bench for input_vc_controller (router at X=1,Y=1): a table of
// per-cycle input/expected-output records plus hand-written corner sequences.
module tb_input_vc_controller;
    localparam int unsigned FW = 18;

    localparam int TH = 0, TB = 1, TT = 2, THT = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    input_vc_controller_if #(.BUFFER_SIZE(8), .DATA_W(16), .VC_SIZE(1)) bus ();

    input_vc_controller #(
        .BUFFER_SIZE(8), .DATA_W(16), .COORD_W(2), .VC_SIZE(1),
        .ROUTER_X(1), .ROUTER_Y(1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .vc_if (bus)
    );

    typedef struct {
        logic          rst_n;
        logic          valid;
        logic [FW-1:0] flit;
        logic          vcv;
        logic          vcn;
        logic          gnt;
        logic          e_vcreq;
        logic [2:0]    e_port;
        logic          e_swreq;
        logic          e_vc;
        logic          e_idle;
        logic [3:0]    e_count;
        logic          e_err;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [FW-1:0] mkf(int t, int dx, int dy, int tag);
        return {12'(tag), 2'(dy), 2'(dx), 2'(t)};
    endfunction

    task automatic add(input int r, input int v, input logic [FW-1:0] f, input int vv,
                       input int vn, input int g, input int eq, input int ep, input int es,
                       input int evc, input int ei, input int ec, input int ee);
        vec_t x;
        x.rst_n = 1'(r);   x.valid = 1'(v);    x.flit = f;
        x.vcv = 1'(vv);    x.vcn = 1'(vn);     x.gnt = 1'(g);
        x.e_vcreq = 1'(eq); x.e_port = 3'(ep); x.e_swreq = 1'(es);
        x.e_vc = 1'(evc);  x.e_idle = 1'(ei);  x.e_count = 4'(ec); x.e_err = 1'(ee);
        vecs.push_back(x);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s step %0d got %0h want %0h", nm, idx, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [FW-1:0] f,
                         input logic vv, input logic vn, input logic g);
        @(negedge clk);
        rst = r; bus.valid_i = v; bus.flit_i = f;
        bus.vc_valid_i = vv; bus.vc_new_i = vn; bus.switch_grant_i = g;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input int idx);
        chk("rst_count", idx, 32'(bus.count_o), 32'd0);
        chk("rst_idle",  idx, 32'(bus.idle_o), 32'd1);
        chk("rst_vcreq", idx, 32'(bus.vc_request_o), 32'd0);
        chk("rst_swreq", idx, 32'(bus.switch_request_o), 32'd0);
        chk("rst_err",   idx, 32'(bus.error_o), 32'd0);
        chk("rst_port",  idx, 32'(bus.out_port_o), 32'd0);
        chk("rst_vc",    idx, 32'(bus.vc_o), 32'd0);
    endtask

    initial begin
        logic [FW-1:0] z;
        logic [FW-1:0] fs;
        int            lat;
        z = '0;
        bus.valid_i = 1'b0; bus.flit_i = '0; bus.vc_valid_i = 1'b0;
        bus.vc_new_i = 1'b0; bus.switch_grant_i = 1'b0;

        // reset state
        add(0,0,z,0,0,0, 0,0,0,0,1,0,0);
        // single HEADTAIL to EAST (2,1)
        add(1,1,mkf(THT,2,1,1),0,0,0, 0,0,0,0,0,1,0);
        add(1,0,z,0,0,0, 1,4,0,0,0,1,0);
        add(1,0,z,1,1,0, 0,4,1,1,0,1,0);
        add(1,0,z,0,0,1, 0,4,0,1,1,0,0);
        // 4-flit packet to LOCAL, second head to NORTH queued during first pop
        add(1,1,mkf(TH,1,1,2),0,0,0, 0,4,0,1,0,1,0);
        add(1,1,mkf(TB,0,0,3),0,0,0, 1,0,0,1,0,2,0);
        add(1,1,mkf(TB,0,0,4),0,0,0, 1,0,0,1,0,3,0);
        add(1,1,mkf(TT,0,0,5),0,0,0, 1,0,0,1,0,4,0);
        add(1,0,z,1,0,0, 0,0,1,0,0,4,0);
        add(1,1,mkf(TH,1,0,6),0,0,1, 0,0,1,0,0,4,0);
        add(1,0,z,0,0,1, 0,0,1,0,0,3,0);
        add(1,0,z,0,0,1, 0,0,1,0,0,2,0);
        add(1,0,z,0,0,1, 0,0,0,0,0,1,0);
        add(1,0,z,0,0,0, 1,1,0,0,0,1,0);
        add(1,0,z,1,1,0, 0,1,1,1,0,1,0);
        add(1,0,z,0,0,1, 0,1,0,1,0,0,0);
        // grant with empty FIFO is an error
        add(1,0,z,0,0,1, 0,1,0,1,0,0,1);
        add(0,0,z,0,0,0, 0,0,0,0,1,0,0);
        // fill to 8, write+grant when full, then overflow
        for (int k = 0; k < 8; k++)
            add(1,1,(k == 0) ? mkf(TH,1,1,16) : mkf(TB,0,0,16+k),0,0,0,
                (k >= 1) ? 1 : 0,0,0,0,0,k+1,0);
        add(1,0,z,1,1,0, 0,0,1,1,0,8,0);
        add(1,1,mkf(TB,0,0,30),0,0,1, 0,0,1,1,0,8,0);
        add(1,1,mkf(TB,0,0,31),0,0,0, 0,0,1,1,0,8,1);
        add(0,0,z,0,0,0, 0,0,0,0,1,0,0);
        // orphan BODY at head in IDLE
        add(1,1,mkf(TB,1,1,64),0,0,0, 0,0,0,0,0,1,0);
        add(1,0,z,0,0,0, 0,0,0,0,1,0,1);
        add(1,0,z,0,0,0, 0,0,0,0,1,0,1);
        add(0,0,z,0,0,0, 0,0,0,0,1,0,0);
        // VA held 5 cycles for a WEST packet, then grant, then spurious grant
        add(1,1,mkf(TH,0,1,80),0,0,0, 0,0,0,0,0,1,0);
        for (int k = 0; k < 5; k++) add(1,0,z,0,0,0, 1,3,0,0,0,1,0);
        add(1,0,z,1,1,0, 0,3,1,1,0,1,0);
        add(1,0,z,1,0,0, 0,3,1,1,0,1,1);

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].valid, vecs[i].flit,
                  vecs[i].vcv, vecs[i].vcn, vecs[i].gnt);
            chk("vc_request", i, 32'(bus.vc_request_o), 32'(vecs[i].e_vcreq));
            chk("out_port",   i, 32'(bus.out_port_o), 32'(vecs[i].e_port));
            chk("switch_req", i, 32'(bus.switch_request_o), 32'(vecs[i].e_swreq));
            chk("vc_o",       i, 32'(bus.vc_o), 32'(vecs[i].e_vc));
            chk("idle",       i, 32'(bus.idle_o), 32'(vecs[i].e_idle));
            chk("count",      i, 32'(bus.count_o), 32'(vecs[i].e_count));
            chk("error",      i, 32'(bus.error_o), 32'(vecs[i].e_err));
        end

        // reset mid-packet in ACTIVE with 3 flits stored
        drive(1'b1, 1'b1, mkf(TB,0,0,81), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, mkf(TB,0,0,82), 1'b0, 1'b0, 1'b0);
        chk("mid_count", 100, 32'(bus.count_o), 32'd3);
        chk("mid_swreq", 100, 32'(bus.switch_request_o), 32'd1);
        drive(1'b0, 1'b0, z, 1'b0, 1'b0, 1'b0);
        chk_reset(101);

        // SOUTH head: flit_o shows it at once, request follows after one cycle
        fs = mkf(TH,1,2,90);
        drive(1'b1, 1'b1, fs, 1'b0, 1'b0, 1'b0);
        chk("head_flit", 102, 32'(bus.flit_o), 32'(fs));
        chk("pre_vcreq", 102, 32'(bus.vc_request_o), 32'd0);
        bus.valid_i = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (bus.vc_request_o) begin
                lat = k;
                break;
            end
        end
        chk("req_latency", 103, 32'(lat), 32'd1);
        chk("south_port",  103, 32'(bus.out_port_o), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
